fl_ctrl: RTL

Allocation controller for the physical-register free list in the 2-wide out-of-order core. It sits between ID and `fl`.
- Each cycle it arbitrates ID's rename request (0–2 registers) against the registered free-register count and drives the granted count into the free list.
- It credits ROB retirements and checkpoints allocation state at branches.
- On a branch mispredict it computes how far the free-list allocation pointer must rewind, then holds dispatch for one cycle.

---
 rtl/panda_pkg.sv | 21 ++
 rtl/fl_ckpt_ring.sv | 77 +++++++
 rtl/fl_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/panda_pkg.sv
// -----------------------------------------------------------------------------
// panda_pkg
// Shared constants and types for the free-list allocation controller.
//   NUM_PR     : physical registers
//   NUM_AR     : architectural registers (reset free count = NUM_PR-NUM_AR)
//   CKPT_DEPTH : branch checkpoint slots (power of 2)
//   PR_W       : width of free count / allocation pointer
// -----------------------------------------------------------------------------
package panda_pkg;

  localparam int unsigned NUM_PR     = 96;
  localparam int unsigned NUM_AR     = 32;
  localparam int unsigned CKPT_DEPTH = 4;
  localparam int unsigned PR_W       = 7;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fl_ctrl_state_t;

endpackage

// File: rtl/fl_ckpt_ring.sv
// -----------------------------------------------------------------------------
// fl_ckpt_ring
// Checkpoint ring holding the allocation pointer captured at each in-flight
// branch. Oldest entry sits at head; new entries are written at tail.
// Ports:
//   clock, reset   : posedge clock, asynchronous active-high reset
//   i_push         : write i_push_data at tail and advance tail
//   i_push_data    : allocation pointer value to checkpoint
//   i_pop          : retire the head entry (ignored when empty)
//   i_flush        : discard all entries (head = tail, count = 0)
//   o_head_data    : checkpoint at head
//   o_tail         : slot the next push will occupy
//   o_cnt          : live entries
//   o_full         : all slots live
// -----------------------------------------------------------------------------
module fl_ckpt_ring #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 7
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [W-1:0]               o_head_data,
  output logic [$clog2(DEPTH)-1:0]   o_tail,
  output logic [$clog2(DEPTH):0]     o_cnt,
  output logic                       o_full
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_cnt;
  logic             w_pop;

  assign w_pop = i_pop & (r_cnt != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push) begin
      r_mem[r_tail] <= i_push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_head <= r_tail;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head_data = r_mem[r_head];
  assign o_tail      = r_tail;
  assign o_cnt       = r_cnt;
  assign o_full      = (r_cnt == FULL_CNT);

endmodule

// File: rtl/fl_ctrl.sv
// -----------------------------------------------------------------------------
// fl_ctrl
// Free-list allocation controller: grants ID rename requests against the
// registered free count, credits retirements, checkpoints the allocation
// pointer at branches and computes the rewind distance on a mispredict.
// Optional feature macro: FL_CTRL_STATS_EN (adds stall_cycles counter/port).
// Ports:
//   clock, reset       : posedge clock, asynchronous active-high reset
//   id_req_num         : registers requested by ID (0..2)
//   id_branch_valid    : dispatch group ends with a branch
//   rob_retire_num     : registers freed by retirement (0..2)
//   ex_br_resolve      : oldest branch resolved
//   ex_br_mispredict   : that resolution mispredicted
//   fl_dispatch_num    : granted count
//   id_stall           : grant below request
//   id_br_tag          : checkpoint slot for the granted branch
//   fl_rewind_num      : allocations to roll back (mispredict cycle only)
//   fl_free_count      : registered free count
//   ckpt_full          : all checkpoint slots live
//   stall_cycles       : saturating count of stall cycles (stats build only)
// -----------------------------------------------------------------------------
module fl_ctrl #(
  parameter int unsigned NUM_PR     = panda_pkg::NUM_PR,
  parameter int unsigned NUM_AR     = panda_pkg::NUM_AR,
  parameter int unsigned CKPT_DEPTH = panda_pkg::CKPT_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [1:0]                    id_req_num,
  input  logic                          id_branch_valid,
  input  logic [1:0]                    rob_retire_num,
  input  logic                          ex_br_resolve,
  input  logic                          ex_br_mispredict,
  output logic [1:0]                    fl_dispatch_num,
  output logic                          id_stall,
  output logic [$clog2(CKPT_DEPTH)-1:0] id_br_tag,
  output logic [panda_pkg::PR_W-1:0]    fl_rewind_num,
  output logic [panda_pkg::PR_W-1:0]    fl_free_count,
  output logic                          ckpt_full
`ifdef FL_CTRL_STATS_EN
 ,output logic [15:0]                   stall_cycles
`endif
);

  import panda_pkg::*;

  localparam int unsigned  IDX_W    = $clog2(CKPT_DEPTH);
  localparam logic [PR_W:0] FREE_MAX = (PR_W+1)'(NUM_PR - NUM_AR);

  fl_ctrl_state_t    r_state;
  logic [PR_W-1:0]   r_count;
  logic [PR_W-1:0]   r_alloc_ptr;

  logic              w_mispredict;
  logic              w_flush_evt;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_grant;
  logic [PR_W-1:0]   w_head_data;
  logic [PR_W-1:0]   w_rewind;
  logic [IDX_W-1:0]  w_tail;
  logic [IDX_W:0]    w_ckpt_cnt;
  logic              w_ckpt_full;
  logic [PR_W:0]     w_count_sum;
  logic [PR_W-1:0]   w_count_nxt;

  assign w_mispredict = ex_br_resolve & ex_br_mispredict;
  // A resolve with no live checkpoint is ignored, so the rewind/flush only
  // happens when there is a head entry to restore from.
  assign w_flush_evt  = w_mispredict & (w_ckpt_cnt != '0);
  assign w_pop        = ex_br_resolve & ~ex_br_mispredict;

  always_comb begin
    w_grant = '0;
    if (r_state == FLUSH || w_mispredict) begin
      w_grant = '0;
    end else if (id_branch_valid && w_ckpt_full) begin
      w_grant = '0;
    end else if (PR_W'(id_req_num) <= r_count) begin
      w_grant = id_req_num;
    end else begin
      w_grant = r_count[1:0];
    end
  end

  assign w_push   = id_branch_valid & (w_grant == id_req_num) & (id_req_num != '0);
  assign w_rewind = w_flush_evt ? (r_alloc_ptr - w_head_data) : '0;

  // Grant never exceeds count, so the subtraction cannot underflow; the extra
  // bit catches credits beyond the reset bound, which are clamped.
  always_comb begin
    w_count_sum = {1'b0, r_count} + {1'b0, w_rewind}
                + (PR_W+1)'(rob_retire_num) - (PR_W+1)'(w_grant);
    w_count_nxt = (w_count_sum > FREE_MAX) ? FREE_MAX[PR_W-1:0] : w_count_sum[PR_W-1:0];
  end

  fl_ckpt_ring #(
    .DEPTH (CKPT_DEPTH),
    .W     (PR_W)
  ) u_ckpt_ring (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (r_alloc_ptr + PR_W'(w_grant)),
    .i_pop       (w_pop),
    .i_flush     (w_flush_evt),
    .o_head_data (w_head_data),
    .o_tail      (w_tail),
    .o_cnt       (w_ckpt_cnt),
    .o_full      (w_ckpt_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_count     <= FREE_MAX[PR_W-1:0];
      r_alloc_ptr <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_flush_evt) begin
        r_alloc_ptr <= w_head_data;
      end else begin
        r_alloc_ptr <= r_alloc_ptr + PR_W'(w_grant);
      end
      case (r_state)
        RUN:     r_state <= w_flush_evt ? FLUSH : RUN;
        FLUSH:   r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  assign fl_dispatch_num = w_grant;
  assign id_stall        = (w_grant < id_req_num);
  assign id_br_tag       = w_tail;
  assign fl_rewind_num   = w_rewind;
  assign fl_free_count   = r_count;
  assign ckpt_full       = w_ckpt_full;

`ifdef FL_CTRL_STATS_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (id_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
